// File: rtl/real_adder64_if.sv
// rtl/real_adder64_if.sv - operand/result bus for the pipelined binary32 adder
//
// Purpose : groups the operand-pair request and the result return of real_adder64.
// Signals : valid_in, a, b (and sub when REAL_ADDER_SUB_EN is defined) driven by the master;
//           valid_out, c driven by the slave (the adder).
// Macro   : REAL_ADDER_SUB_EN adds the sub request bit.
`timescale 1ns/1ps
interface real_adder64_if #(
    parameter int W = 32
);
    logic         valid_in;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef REAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         valid_out;
    logic [W-1:0] c;

`ifdef REAL_ADDER_SUB_EN
    modport master (output valid_in, a, b, sub, input valid_out, c);
    modport slave  (input valid_in, a, b, sub, output valid_out, c);
`else
    modport master (output valid_in, a, b, input valid_out, c);
    modport slave  (input valid_in, a, b, output valid_out, c);
`endif
endinterface

// File: rtl/real_adder64.sv
// rtl/real_adder64.sv - three-stage pipelined IEEE-754 binary32 adder
//
// Purpose : one operand pair per cycle, round-to-nearest-even sum three cycles later.
//           S1 unpack/align, S2 add/normalize, S3 round/pack. Denormals flush to zero.
// Ports   : clk  - clock, rising edge
//           rst  - synchronous active-high reset (clears valids and c)
//           s_if - real_adder64_if.slave: valid_in, a, b, [sub] in; valid_out, c out
// Macro   : REAL_ADDER_SUB_EN - when defined, s_if.sub=1 computes a-b.
`timescale 1ns/1ps
module real_adder64 #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic            clk,
    input  logic            rst,
    real_adder64_if.slave   s_if
);
    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int SW  = FRAC_W + 1;        // significand with hidden bit
    localparam int GW  = SW + 2;            // plus guard and round
    localparam int XW  = SW + 3;            // plus sticky
    localparam int EIW = EXP_W + 2;         // working exponent, MSB acts as sign
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};

    // Leading-zero count; an all-zero input returns XW.
    function automatic logic [EIW-1:0] f_lzc(input logic [XW-1:0] v);
        f_lzc = EIW'(XW);
        for (int i = 0; i < XW; i++)
            if (v[i]) f_lzc = EIW'(XW - 1 - i);
    endfunction

    // ---------------- S1: unpack, order by magnitude, align ----------------
    logic             w_sign_a, w_sign_b;
    logic [EXP_W-1:0] w_exp_a, w_exp_b, w_exp_x, w_exp_y, w_diff;
    logic [FRAC_W-1:0] w_frac_a, w_frac_b, w_frac_x, w_frac_y;
    logic [W-2:0]     w_mag_a, w_mag_b;
    logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_a_big, w_sign_x, w_sign_y;
    logic [SW-1:0]    w_sig_x, w_sig_y;
    logic [2*GW-1:0]  w_ext;
    logic [XW-1:0]    w_sig_y_al;
    logic             w_special;
    logic [W-1:0]     w_special_val;

    assign w_sign_a = s_if.a[W-1];
`ifdef REAL_ADDER_SUB_EN
    assign w_sign_b = s_if.b[W-1] ^ s_if.sub;
`else
    assign w_sign_b = s_if.b[W-1];
`endif
    assign w_exp_a  = s_if.a[W-2:FRAC_W];
    assign w_exp_b  = s_if.b[W-2:FRAC_W];
    assign w_frac_a = s_if.a[FRAC_W-1:0];
    assign w_frac_b = s_if.b[FRAC_W-1:0];

    always_comb begin
        w_nan_a = (w_exp_a == EXP_MAX) && (w_frac_a != '0);
        w_nan_b = (w_exp_b == EXP_MAX) && (w_frac_b != '0);
        w_inf_a = (w_exp_a == EXP_MAX) && (w_frac_a == '0);
        w_inf_b = (w_exp_b == EXP_MAX) && (w_frac_b == '0);
        // Denormals compare as zero so they can never be chosen over a real zero-sized peer.
        w_mag_a = (w_exp_a == '0) ? '0 : s_if.a[W-2:0];
        w_mag_b = (w_exp_b == '0) ? '0 : s_if.b[W-2:0];
        w_a_big = (w_mag_a >= w_mag_b);

        w_sign_x = w_a_big ? w_sign_a : w_sign_b;
        w_sign_y = w_a_big ? w_sign_b : w_sign_a;
        w_exp_x  = w_a_big ? w_exp_a  : w_exp_b;
        w_exp_y  = w_a_big ? w_exp_b  : w_exp_a;
        w_frac_x = w_a_big ? w_frac_a : w_frac_b;
        w_frac_y = w_a_big ? w_frac_b : w_frac_a;
        w_sig_x  = (w_exp_x == '0) ? '0 : {1'b1, w_frac_x};
        w_sig_y  = (w_exp_y == '0) ? '0 : {1'b1, w_frac_y};
        w_diff   = w_exp_x - w_exp_y;

        // Shift within a double-width field so every bit that falls off lands in the sticky OR.
        w_ext      = {w_sig_y, 2'b00, {GW{1'b0}}} >> w_diff;
        w_sig_y_al = {w_ext[2*GW-1:GW], |w_ext[GW-1:0]};
        if (w_diff >= EXP_W'(GW))
            w_sig_y_al = {{GW{1'b0}}, |w_sig_y};

        w_special     = 1'b0;
        w_special_val = '0;
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sign_a != w_sign_b))) begin
            w_special     = 1'b1;
            w_special_val = QNAN;
        end else if (w_inf_a || w_inf_b) begin
            w_special     = 1'b1;
            w_special_val = {(w_inf_a ? w_sign_a : w_sign_b), EXP_MAX, {FRAC_W{1'b0}}};
        end
    end

    logic             r_s1_valid, r_s1_sign_x, r_s1_eff_sub, r_s1_zero_sign, r_s1_special;
    logic [EXP_W-1:0] r_s1_exp;
    logic [SW-1:0]    r_s1_sig_x;
    logic [XW-1:0]    r_s1_sig_y;
    logic [W-1:0]     r_s1_special_val;

    // ---------------- S2: add/subtract, normalize ----------------
    logic [XW:0]      w_sum;
    logic [XW-1:0]    w_norm;
    logic [EIW-1:0]   w_lzc, w_exp_n;
    logic             w_sum_zero, w_s2_zero, w_s2_sign;

    always_comb begin
        // X >= Y in magnitude, so the subtract never goes negative.
        w_sum = r_s1_eff_sub ? ({1'b0, r_s1_sig_x, 3'b000} - {1'b0, r_s1_sig_y})
                             : ({1'b0, r_s1_sig_x, 3'b000} + {1'b0, r_s1_sig_y});
        w_lzc      = f_lzc(w_sum[XW-1:0]);
        w_sum_zero = (w_sum == '0);
        if (w_sum[XW]) begin
            w_norm  = {w_sum[XW:2], w_sum[1] | w_sum[0]};
            w_exp_n = {2'b00, r_s1_exp} + EIW'(1);
        end else begin
            w_norm  = w_sum[XW-1:0] << w_lzc;
            w_exp_n = {2'b00, r_s1_exp} - w_lzc;
        end
        // Exponent at or below zero means the result is subnormal: flush it.
        w_s2_zero = w_sum_zero || w_exp_n[EIW-1] || (w_exp_n == '0);
        // Exact zero is -0 only when both addends were negative zeros.
        w_s2_sign = w_sum_zero ? r_s1_zero_sign : r_s1_sign_x;
    end

    logic             r_s2_valid, r_s2_sign, r_s2_zero, r_s2_special;
    logic [EIW-1:0]   r_s2_exp;
    logic [SW-1:0]    r_s2_mant;
    logic [2:0]       r_s2_grs;
    logic [W-1:0]     r_s2_special_val;

    // ---------------- S3: round to nearest even, pack ----------------
    logic             w_round_up;
    logic [SW:0]      w_mant_r;
    logic [FRAC_W-1:0] w_frac_r;
    logic [EIW-1:0]   w_exp_r;
    logic [W-1:0]     w_result;

    always_comb begin
        w_round_up = r_s2_grs[2] & (r_s2_grs[1] | r_s2_grs[0] | r_s2_mant[0]);
        w_mant_r   = {1'b0, r_s2_mant} + {{SW{1'b0}}, w_round_up};
        // A carry out of rounding means the mantissa wrapped to 1.000..; bump the exponent.
        w_frac_r   = w_mant_r[SW] ? w_mant_r[SW-1:1] : w_mant_r[FRAC_W-1:0];
        w_exp_r    = r_s2_exp + EIW'(w_mant_r[SW]);
        if (r_s2_special)
            w_result = r_s2_special_val;
        else if (r_s2_zero)
            w_result = {r_s2_sign, {(W-1){1'b0}}};
        else if (w_exp_r >= {2'b00, EXP_MAX})
            w_result = {r_s2_sign, EXP_MAX, {FRAC_W{1'b0}}};
        else
            w_result = {r_s2_sign, w_exp_r[EXP_W-1:0], w_frac_r};
    end

    logic             r_valid_out;
    logic [W-1:0]     r_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_valid_out <= 1'b0;
            r_c         <= '0;
        end else begin
            r_s1_valid  <= s_if.valid_in;
            r_s2_valid  <= r_s1_valid;
            r_valid_out <= r_s2_valid;
            if (r_s2_valid)
                r_c <= w_result;
        end
    end

    // Datapath registers carry no reset; the valid chain qualifies them.
    always_ff @(posedge clk) begin
        if (s_if.valid_in) begin
            r_s1_sign_x      <= w_sign_x;
            r_s1_eff_sub     <= w_sign_x ^ w_sign_y;
            r_s1_zero_sign   <= w_sign_a & w_sign_b;
            r_s1_exp         <= w_exp_x;
            r_s1_sig_x       <= w_sig_x;
            r_s1_sig_y       <= w_sig_y_al;
            r_s1_special     <= w_special;
            r_s1_special_val <= w_special_val;
        end
        if (r_s1_valid) begin
            r_s2_sign        <= w_s2_sign;
            r_s2_zero        <= w_s2_zero;
            r_s2_exp         <= w_exp_n;
            r_s2_mant        <= w_norm[XW-1:3];
            r_s2_grs         <= w_norm[2:0];
            r_s2_special     <= r_s1_special;
            r_s2_special_val <= r_s1_special_val;
        end
    end

    assign s_if.valid_out = r_valid_out;
    assign s_if.c         = r_c;
endmodule

// File: tb/tb_real_adder64.sv
// tb/tb_real_adder64.sv - directed self-checking bench for real_adder64
`timescale 1ns/1ps
module tb_real_adder64;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    real_adder64_if bus ();
    real_adder64 dut (.clk(clk), .rst(rst), .s_if(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // One pair, then confirm nothing at edge N+2 and the result at edge N+3.
    task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] vc);
        @(negedge clk);
        bus.a = va; bus.b = vb; bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        @(negedge clk);
        check({tag, "/early"}, {31'b0, bus.valid_out}, 32'd0);
        @(negedge clk);
        check({tag, "/valid"}, {31'b0, bus.valid_out}, 32'd1);
        check(tag, bus.c, vc);
    endtask

    logic [31:0] bb_a [4];
    logic [31:0] bb_b [4];
    logic [31:0] bb_c [4];

    initial begin
        rst = 1'b1; bus.valid_in = 1'b0; bus.a = '0; bus.b = '0;
`ifdef REAL_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, bus.valid_out}, 32'd0);
        check("rst_c", bus.c, 32'h0);
        rst = 1'b0;

        run_vec("add_2p4_3p7",   32'h4019999A, 32'h406CCCCD, 32'h40C33334);
        run_vec("one_minus_one", 32'h3F800000, 32'hBF800000, 32'h00000000);
        run_vec("max_overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        run_vec("round_ovf",     32'h7F7FFFFF, 32'h73000000, 32'h7F800000);
        run_vec("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000);
        run_vec("snan",          32'h7FA00000, 32'h3F800000, 32'h7FC00000);
        run_vec("qnan_payload",  32'h3F800000, 32'h7FC00001, 32'h7FC00000);
        run_vec("inf_plus_fin",  32'h3F800000, 32'h7F800000, 32'h7F800000);
        run_vec("ninf_ninf",     32'hFF800000, 32'hFF800000, 32'hFF800000);
        run_vec("x_plus_zero",   32'h3F800000, 32'h00000000, 32'h3F800000);
        run_vec("zero_plus_x",   32'h00000000, 32'hC0490FDB, 32'hC0490FDB);
        run_vec("nz_plus_nz",    32'h80000000, 32'h80000000, 32'h80000000);
        run_vec("pz_plus_nz",    32'h00000000, 32'h80000000, 32'h00000000);
        run_vec("denorm_flush",  32'h00000001, 32'h80000000, 32'h00000000);
        run_vec("tie_even_down", 32'h3F800000, 32'h33800000, 32'h3F800000);
        run_vec("tie_odd_up",    32'h3F800001, 32'h33800000, 32'h3F800002);
        run_vec("above_half",    32'h3F800000, 32'h33800001, 32'h3F800001);
        run_vec("far_sticky",    32'h3F800000, 32'h30800000, 32'h3F800000);
        run_vec("round_renorm",  32'h3FFFFFFF, 32'h33800000, 32'h40000000);
        run_vec("cancel_lzc",    32'h3F800001, 32'hBF800000, 32'h34000000);
        run_vec("neg_plus_big",  32'hBF800000, 32'h40000000, 32'h3F800000);
        run_vec("underflow_neg", 32'h80C00000, 32'h00800000, 32'h80000000);

`ifdef REAL_ADDER_SUB_EN
        bus.sub = 1'b1;
        run_vec("sub_3p7_2p4",   32'h406CCCCD, 32'h4019999A, 32'h3FA66666);
        run_vec("sub_one_one",   32'h3F800000, 32'h3F800000, 32'h00000000);
        bus.sub = 1'b0;
`endif

        // Back-to-back: four pairs on consecutive cycles.
        bb_a = '{32'h3F800000, 32'h4019999A, 32'h3F800000, 32'h3F800001};
        bb_b = '{32'h3F800000, 32'h406CCCCD, 32'hBF800000, 32'hBF800000};
        bb_c = '{32'h40000000, 32'h40C33334, 32'h00000000, 32'h34000000};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 3 && i < 7) begin
                check($sformatf("b2b_valid%0d", i - 3), {31'b0, bus.valid_out}, 32'd1);
                check($sformatf("b2b_c%0d", i - 3), bus.c, bb_c[i - 3]);
            end
            if (i == 7) begin
                check("b2b_tail_valid", {31'b0, bus.valid_out}, 32'd0);
                check("b2b_hold_c", bus.c, 32'h34000000);
            end
            if (i < 4) begin
                bus.a = bb_a[i]; bus.b = bb_b[i]; bus.valid_in = 1'b1;
            end else begin
                bus.valid_in = 1'b0;
            end
        end

        // Reset with two pairs in flight: neither may emerge.
        @(negedge clk);
        bus.a = 32'h3F800000; bus.b = 32'h3F800000; bus.valid_in = 1'b1;
        @(negedge clk);
        bus.a = 32'h40000000; bus.b = 32'h40000000;
        @(negedge clk);
        bus.valid_in = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_c", bus.c, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("midrst_valid%0d", i), {31'b0, bus.valid_out}, 32'd0);
            @(negedge clk);
        end
        check("midrst_c_hold", bus.c, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
